// File: rtl/multi_chan_mem_intf.sv
// Multi-channel request front end for a single-port memory.
// Each channel latches one request; a round-robin FSM issues them to memory one at a time.
module multi_chan_mem_intf #(
  parameter int NCH = 4,
  parameter int DW  = 16,
  parameter int AW  = 14,
  parameter int TMO = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    store,
  input  logic [NCH-1:0]    load,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    done,
  output logic [NCH-1:0]    error,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic              write_req,
  output logic              read_req,
  output logic [AW-1:0]     addrout,
  output logic [DW-1:0]     datatomem,
  input  logic [DW-1:0]     datafrommem,
  input  logic              mem_resp
);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state_q;
  logic [NCH-1:0] pend_q, op_q, done_q, err_q;
  logic [AW-1:0]  addr_q [NCH];
  logic [DW-1:0]  wdat_q [NCH];
  logic [GW-1:0]  last_q, gnt_q, gnt_d;
  logic [7:0]     cnt_q;
  logic [DW-1:0]  rdata_q, dout_q;
  logic [AW-1:0]  aout_q;
  logic           wr_q, rd_q;

  logic [NCH-1:0] cap, cerr, clr, terr, gsel;
  logic           found, tmo_hit;

  // Capture stage: accept exactly-one-of store/load on idle channels, flag everything else
  always_comb begin
    cap  = '0;
    cerr = '0;
    for (int i = 0; i < NCH; i++) begin
      cap[i]  = (store[i] ^ load[i]) & ~pend_q[i];
      cerr[i] = (store[i] & load[i]) | ((store[i] | load[i]) & pend_q[i]);
    end
  end

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gnt_d = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(last_q) + k) % NCH;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        gnt_d = GW'(idx);
      end
    end
  end

  always_comb begin
    gsel        = '0;
    gsel[gnt_q] = 1'b1;
    tmo_hit     = (state_q == WAIT) && !mem_resp && (cnt_q == 8'(TMO - 1));
    clr         = ((state_q == DONE) || tmo_hit) ? gsel : '0;
    terr        = tmo_hit ? gsel : '0;
  end

  // Control stage: pending bits, pulses and the memory handshake FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      aout_q  <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      last_q  <= GW'(NCH - 1);
    end else begin
      pend_q <= (pend_q & ~clr) | cap;
      err_q  <= cerr | terr;
      done_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            gnt_q   <= gnt_d;
            wr_q    <= ~op_q[gnt_d];
            rd_q    <= op_q[gnt_d];
            aout_q  <= addr_q[gnt_d];
            dout_q  <= wdat_q[gnt_d];
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (mem_resp) begin
            if (op_q[gnt_q]) rdata_q <= datafrommem;
            done_q  <= gsel;
            state_q <= DONE;
          end else if (tmo_hit) begin
            last_q  <= gnt_q;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          last_q  <= gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request latches hold their value until the channel is cleared
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (cap[i]) begin
        op_q[i]   <= load[i];
        addr_q[i] <= addr[i*AW +: AW];
        wdat_q[i] <= wdata[i*DW +: DW];
      end
    end
  end

  assign done      = done_q;
  assign error     = err_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign write_req = wr_q;
  assign read_req  = rd_q;
  assign addrout   = aout_q;
  assign datatomem = dout_q;
endmodule

// File: doc/multi_chan_mem_intf.md
MULTI_CHAN_MEM_INTF -- requirements
Module: multi_chan_mem_intf

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter NCH, default 4, SHALL set the number of requester channels (legal range 2..8).
REQ-003 Parameter DW, default 16, SHALL set the data width of both the write and the read paths.
REQ-004 Parameter AW, default 14, SHALL set the memory address width.
REQ-005 Parameter TMO, default 15, SHALL set the maximum number of WAIT cycles allowed for mem_resp (legal range 1..255).
REQ-006 The ports SHALL be, in order:
- clk  in  1  clock, rising-edge active.
- reset  in  1  synchronous active-high reset.
- store  in  NCH  per-channel write request pulse.
- load  in  NCH  per-channel read request pulse.
- addr  in  NCH*AW  per-channel address; channel i occupies bits [i*AW +: AW].
- wdata  in  NCH*DW  per-channel write data; channel i occupies bits [i*DW +: DW].
- done  out  NCH  per-channel one-cycle completion pulse.
- error  out  NCH  per-channel one-cycle error pulse.
- rdata  out  DW  read data, valid in the cycle done is high.
- busy  out  1  high in every state other than IDLE.
- write_req  out  1  memory write strobe.
- read_req  out  1  memory read strobe.
- addrout  out  AW  memory address.
- datatomem  out  DW  memory write data.
- datafrommem  in  DW  memory read data.
- mem_resp  in  1  memory completion strobe.

Function
REQ-007 Capture: for each channel i that is not pending and sees exactly one of store[i] or load[i] high, the block SHALL register pending[i], the opcode, addr and wdata at that clock edge.
REQ-008 A request arriving on a channel that is already pending SHALL be dropped; error[i] SHALL pulse high for one cycle starting the next cycle.
REQ-009 If store[i] and load[i] are high in the same cycle, the request SHALL be dropped with the same error[i] pulse.
REQ-010 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-011 In IDLE with any pending bit set, the block SHALL grant by round-robin, searching from (last_grant+1) mod NCH, and SHALL move to ISSUE. The search SHALL see only pending bits registered at or before the current edge.
REQ-012 In ISSUE, the block SHALL drive write_req or read_req high for exactly one cycle, with addrout and datatomem taken from the granted channel's latched values, and SHALL move to WAIT.
REQ-013 In WAIT, the block SHALL count cycles from 0.
- If mem_resp is high: latch datafrommem for reads, then go to DONE.
- If the count reaches TMO without mem_resp: go to IDLE, pulse error[g] for one cycle, clear pending[g], update last_grant, and assert no done.
REQ-014 In DONE, the block SHALL:
- pulse done[g] for one cycle;
- drive rdata with the latched read data for loads, or keep its previous value for stores;
- clear pending[g];
- set last_grant to g;
- return to IDLE.
REQ-015 mem_resp SHALL be ignored in IDLE, ISSUE and DONE.
REQ-016 Latency SHALL be fixed:
- request captured at edge 0 -> ISSUE strobe in cycle 2;
- mem_resp in cycle k -> done[g] in cycle k+1;
- minimum total latency is 4 cycles when mem_resp arrives in cycle 3.
REQ-017 A pending channel's latched request SHALL remain stable until it is cleared; a new request on that channel SHALL be accepted in the cycle after done or error clears it.
REQ-018 write_req and read_req SHALL never be high together, and SHALL be high only in ISSUE.
REQ-019 At most one done bit SHALL be high in any cycle.
REQ-020 error pulses from the capture path (REQ-008/009) and the timeout path (REQ-013) SHALL be ORed per channel.

Reset
REQ-021 While reset is high at a rising edge, the following SHALL be cleared to zero: state (to IDLE), pending, done, error, rdata, busy, write_req, read_req, addrout, datatomem and the WAIT counter; last_grant SHALL be set to NCH-1, so channel 0 wins first.
REQ-022 Reset mid-operation SHALL abandon the outstanding transfer without done or error; a mem_resp arriving after reset SHALL be ignored.

Verification
REQ-023 Single store, ch1, addr=0x0123, wdata=0xBEEF, mem_resp in cycle 3 -> write_req=1 in cycle 2 with addrout=0x0123 and datatomem=0xBEEF; done=4'b0010 in cycle 4.
REQ-024 store on all 4 channels in the same cycle after reset -> service order 0,1,2,3; exactly one done bit per completion.
REQ-025 load ch2, datafrommem=0x5A5A held with mem_resp -> rdata=0x5A5A while done[2]=1.
REQ-026 load ch0 with no mem_resp -> error[0] pulses exactly TMO cycles after WAIT entry; busy drops; done stays 0.
REQ-027 store and load both high on ch3 in the same cycle, plus a repeat request on pending ch1 -> error[3] and error[1] each pulse once; no memory strobe for either dropped request.
REQ-028 reset asserted during WAIT, then mem_resp pulsed -> all outputs 0, no done; the next request behaves as in REQ-023.
